bcd_serial_add_ctrl: RTL and testbench
======================================

// Module: bcd_serial_add_ctrl
// PURPOSE
// - Digit-serial controller for multi-digit packed-BCD addition.
// - One shared 1-digit BCD add/correct stage is sequenced over N digits, LSD first.
// - Carry is kept in a register between digit steps.
// - Sits between operand producers and result consumers in the BCD datapath.
// - Valid/ready handshake on both sides.
// - Same arithmetic result as the parallel BCD adder, in less area, at N_DIGIT_OPERANDS cycles per op.
// PARAMETERS
// - N_DIGIT_OPERANDS  4  number of BCD digits per operand (>=1)
// PORTS
// - clk        in   1          single clock, rising edge
// - rst        in   1          asynchronous, active-high reset
// - in_valid   in   1          operands A, B, cin are valid
// - in_ready   out  1          controller can accept an operation
// - A          in   4*N        first operand, packed BCD
// - B          in   4*N        second operand, packed BCD
// - cin        in   1          carry-in
// - out_valid  out  1          S (and err) are valid
// - out_ready  in   1          consumer accepts S
// - S          out  4*N+4      packed BCD sum; top nibble is 4'h0 or 4'h1
// - busy       out  1          high in ADD and DONE
// - err        out  1          non-BCD input digit detected (see CONFIGURATION)
// BEHAVIOUR
// - States:
//   - IDLE: in_ready=1.
//   - ADD: digit loop.
//   - DONE: out_valid=1.
// - Reset (async, immediate): state=IDLE, digit counter=0, carry=0, S=0, out_valid=0, err=0.
//   - in_ready=1 once rst deasserts.
//   - Reset mid-ADD or mid-DONE discards the operation; no out_valid is produced.
// - IDLE -> ADD on edge with in_valid&&in_ready.
//   - That edge captures A, B into shift registers, sets carry=cin, counter=0, clears S.
// - ADD, one digit per cycle: t = a_i + b_i + carry, as a 5-bit value.
//   - t>9: digit=(t+6)[3:0], carry<=1.
//   - t<=9: digit=t[3:0], carry<=0.
//   - The digit is written to S[4i+3:4i].
//   - Counter increments; it wraps on ADD exit and never exceeds N-1.
// - ADD -> DONE on the edge processing digit N-1.
//   - Same edge writes S[4N+3:4N] = {3'b0, final carry}.
// - Latency: out_valid rises exactly N_DIGIT_OPERANDS edges after the accept edge.
// - DONE: out_valid=1 and S stable until the out_valid&&out_ready edge, then -> IDLE.
//   - in_ready=0 throughout ADD and DONE; in_valid is ignored.
//   - A new op is accepted at the earliest one cycle after result handoff; no same-edge accept.
// - out_ready high before DONE has no effect. S holds the last result in IDLE.
// - A/B/cin changes after the accept edge do not affect the result.
// CONFIGURATION
// - BCD_INVALID_CHECK_EN defined:
//   - On the accept edge, flag any nibble of A or B >9; err is valid with out_valid.
//   - err is held through DONE and cleared on the next accept or on reset.
//   - S is still computed by the digit formula above. err is never raised for valid digits.
// - BCD_INVALID_CHECK_EN undefined: err tied 0, no check logic.
// TESTING (N_DIGIT_OPERANDS=4, out_ready=1 unless stated)
// - A=0x0007, B=0x0008, cin=0 -> 4 cycles later out_valid=1, S=0x00015. With cin=1 -> S=0x00016.
// - A=0x0029, B=0x0017, cin=0 -> S=0x00046. A=0x0050, B=0x0050, cin=1 -> S=0x00101.
// - A=0x9999, B=0x9999, cin=0 -> S=0x19998 (carry into top nibble).
// - Backpressure: out_ready=0 for 3 cycles in DONE -> S, out_valid held, in_ready=0;
//   - out_ready=1 -> IDLE next edge.
// - Async rst pulse 2 cycles after accept -> out_valid=0, in_ready=1 after release.
//   - Next op 0x0001+0x0001 -> S=0x00002.
// - With BCD_INVALID_CHECK_EN: A=0x000A, B=0x0000 -> err=1 with out_valid.
//   - Following op 0x0001+0x0002 -> err=0, S=0x00003.

Source files
------------

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl
// Digit-serial packed-BCD adder controller. A single 1-digit BCD add/correct
// stage is stepped over N_DIGIT_OPERANDS digits, least significant digit
// first. The carry is held in a register between digit steps. Operands come
// in, and the result goes out, over valid/ready handshakes.
//
// Optional feature: define BCD_INVALID_CHECK_EN to flag operand nibbles
// above 9 on err. When it is undefined, err is tied low and no check logic
// is built.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an operation; in_ready=1; S holds the last result
// ADD   | one digit per cycle, LSD first; the carry rides in carry_q
// DONE  | result presented; out_valid=1 until the out_ready handshake

module bcd_serial_add_ctrl #(
    parameter int N_DIGIT_OPERANDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [4*N_DIGIT_OPERANDS-1:0] A,
    input  logic [4*N_DIGIT_OPERANDS-1:0] B,
    input  logic                          cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [4*N_DIGIT_OPERANDS+3:0] S,
    output logic                          busy,
    output logic                          err
);

    localparam int N  = N_DIGIT_OPERANDS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [4*N-1:0]  a_sh;
    logic [4*N-1:0]  b_sh;
    logic            carry_q;
    logic [CW-1:0]   cnt_q;
    logic [4*N+3:0]  s_q;

    logic            accept;
    logic            last_digit;
    logic [4:0]      digit_raw;
    logic [3:0]      digit;
    logic            carry_nx;

    assign accept     = in_valid && in_ready;
    assign last_digit = (state_q == ST_ADD) && (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs. A result handoff always returns to
    // IDLE first, so there is never a same-edge accept.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                busy = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shared 1-digit BCD add/correct stage on the current low nibbles.
    // Adding 6 modulo 16 gives the corrected digit for sums from 10 to 19.
    always_comb begin
        digit_raw = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry_q};
        digit     = digit_raw[3:0];
        carry_nx  = 1'b0;
        if (digit_raw > 5'd9) begin
            digit    = digit_raw[3:0] + 4'd6;
            carry_nx = 1'b1;
        end
    end

    // Operand shift registers, carry, digit counter and the result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
        end else if (accept) begin
            a_sh    <= A;
            b_sh    <= B;
            carry_q <= cin;
            cnt_q   <= '0;
            s_q     <= '0;
        end else if (state_q == ST_ADD) begin
            a_sh    <= a_sh >> 4;
            b_sh    <= b_sh >> 4;
            carry_q <= carry_nx;
            cnt_q   <= last_digit ? '0 : cnt_q + 1'b1;
            for (int i = 0; i < N; i++) begin
                if (cnt_q == CW'(i)) begin
                    s_q[4*i +: 4] <= digit;
                end
            end
            if (last_digit) begin
                s_q[4*N +: 4] <= {3'b000, carry_nx};
            end
        end
    end

    assign S = s_q;

`ifdef BCD_INVALID_CHECK_EN
    logic err_q;
    logic bad_nibble;

    // Any operand nibble above 9 marks the whole operation.
    always_comb begin
        bad_nibble = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ((A[4*i +: 4] > 4'd9) || (B[4*i +: 4] > 4'd9)) begin
                bad_nibble = 1'b1;
            end
        end
    end

    // The flag is captured at accept and held until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= bad_nibble;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl
// Self-checking bench for bcd_serial_add_ctrl (N_DIGIT_OPERANDS=4). Expected
// sums come from decimal arithmetic on the operand values.

module tb_bcd_serial_add_ctrl;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [4*N-1:0] A;
    logic [4*N-1:0] B;
    logic           cin;
    logic           out_valid;
    logic           out_ready;
    logic [4*N+3:0] S;
    logic           busy;
    logic           err;

    int n_chk;
    int n_pass;

    bcd_serial_add_ctrl #(.N_DIGIT_OPERANDS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bcd_to_int(input logic [4*N-1:0] v);
        int r = 0;
        int p = 1;
        for (int i = 0; i < N; i++) begin
            r = r + int'(v[4*i +: 4]) * p;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [4*N+3:0] ref_sum(input logic [4*N-1:0] a,
                                               input logic [4*N-1:0] b,
                                               input logic c);
        int v;
        logic [4*N+3:0] r;
        v = bcd_to_int(a) + bcd_to_int(b) + int'(c);
        r = '0;
        for (int i = 0; i <= N; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [4*N-1:0] rand_bcd();
        logic [4*N-1:0] r;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Waits (bounded) for in_ready, presents one operation for exactly the
    // accept edge, then scrambles the operand inputs.
    task automatic start_op(input logic [4*N-1:0] a, input logic [4*N-1:0] b,
                            input logic c);
        int w = 0;
        while (!in_ready && w < 30) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            n_chk++;
            $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
        end
        A = a; B = b; cin = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = 16'($urandom); B = 16'($urandom); cin = 1'($urandom);
    endtask

    // Counts edges after the accept edge until out_valid (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (S !== 20'h0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            busy !== 1'b0 || err !== 1'b0) begin
            $display("FAIL reset_state: S=%h ov=%b ir=%b busy=%b err=%b required S=0 ov=0 ir=1 busy=0 err=0",
                     S, out_valid, in_ready, busy, err);
        end else n_pass++;
    endtask

    task automatic test_directed();
        logic [15:0] va [5] = '{16'h0007, 16'h0007, 16'h0029, 16'h0050, 16'h9999};
        logic [15:0] vb [5] = '{16'h0008, 16'h0008, 16'h0017, 16'h0050, 16'h9999};
        logic        vc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [19:0] vs [5] = '{20'h00015, 20'h00016, 20'h00046, 20'h00101, 20'h19998};
        int lat;
        logic [19:0] held;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            start_op(va[k], vb[k], vc[k]);
            n_chk++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                $display("FAIL dir_busy[%0d]: busy=%b ir=%b required busy=1 ir=0", k, busy, in_ready);
            end else n_pass++;
            wait_done(lat);
            n_chk++;
            if (lat !== 4) $display("FAIL dir_latency[%0d]: got %0d required 4", k, lat);
            else n_pass++;
            n_chk++;
            if (S !== vs[k] || err !== 1'b0) begin
                $display("FAIL dir_sum[%0d]: S=%h err=%b required S=%h err=0", k, S, err, vs[k]);
            end else n_pass++;
            held = S;
            @(posedge clk); #1;
            n_chk++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || S !== held) begin
                $display("FAIL dir_handoff[%0d]: ov=%b ir=%b S=%h required ov=0 ir=1 S=%h",
                         k, out_valid, in_ready, S, held);
            end else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [19:0] exp_s;
        int bad;
        exp_s = ref_sum(16'h1234, 16'h5678, 1'b1);
        out_ready = 1'b0;
        start_op(16'h1234, 16'h5678, 1'b1);
        wait_done(lat);
        n_chk++;
        if (lat !== 4 || S !== exp_s) begin
            $display("FAIL bp_result: lat=%0d S=%h required lat=4 S=%h", lat, S, exp_s);
        end else n_pass++;
        bad = 0;
        in_valid = 1'b1; A = 16'h0001; B = 16'h0001; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || S !== exp_s || in_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        n_chk++;
        if (bad != 0) begin
            $display("FAIL bp_hold: %0d bad cycles (ov=%b S=%h ir=%b) required 0", bad, out_valid, S, in_ready);
        end else n_pass++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL bp_release: ov=%b ir=%b busy=%b required ov=0 ir=1 busy=0", out_valid, in_ready, busy);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [19:0] exp_s;
        out_ready = 1'b1;
        start_op(16'h0456, 16'h0789, 1'b0);
        wait_done(lat);
        exp_s = ref_sum(16'h2001, 16'h3999, 1'b1);
        A = 16'h2001; B = 16'h3999; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL b2b_no_same_edge: ir=%b busy=%b ov=%b required ir=1 busy=0 ov=0", in_ready, busy, out_valid);
        end else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = 16'($urandom); B = 16'($urandom);
        n_chk++;
        if (busy !== 1'b1) $display("FAIL b2b_accept: busy=%b required 1", busy);
        else n_pass++;
        wait_done(lat);
        n_chk++;
        if (lat !== 4 || S !== exp_s) begin
            $display("FAIL b2b_sum: lat=%0d S=%h required lat=4 S=%h", lat, S, exp_s);
        end else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat;
        int bp;
        logic [15:0] a;
        logic [15:0] b;
        logic c;
        logic [19:0] exp_s;
        int bad_lat = 0;
        int bad_sum = 0;
        int bad_hold = 0;
        for (int k = 0; k < 40; k++) begin
            a = rand_bcd(); b = rand_bcd(); c = 1'($urandom);
            exp_s = ref_sum(a, b, c);
            out_ready = 1'($urandom);
            start_op(a, b, c);
            wait_done(lat);
            if (lat != 4) bad_lat++;
            if (S !== exp_s || err !== 1'b0) begin
                bad_sum++;
                $display("FAIL rand_sum[%0d]: %h+%h+%0b S=%h required %h", k, a, b, c, S, exp_s);
            end
            bp = $urandom_range(0, 2);
            out_ready = 1'b0;
            for (int i = 0; i < bp; i++) begin
                @(posedge clk); #1;
                if (out_valid !== 1'b1 || S !== exp_s) bad_hold++;
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || S !== exp_s) bad_hold++;
        end
        n_chk++;
        if (bad_lat != 0) $display("FAIL rand_latency: %0d ops off required 0", bad_lat);
        else n_pass++;
        n_chk++;
        if (bad_sum != 0) $display("FAIL rand_sums: %0d wrong required 0", bad_sum);
        else n_pass++;
        n_chk++;
        if (bad_hold != 0) $display("FAIL rand_hold: %0d bad cycles required 0", bad_hold);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        int lat;
        out_ready = 1'b1;
        start_op(16'h4444, 16'h5555, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || S !== 20'h0 || busy !== 1'b0) begin
            $display("FAIL rst_async: ov=%b S=%h busy=%b required ov=0 S=0 busy=0", out_valid, S, busy);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        n_chk++;
        if (seen != 0 || in_ready !== 1'b1) begin
            $display("FAIL rst_discard: ov_cycles=%0d ir=%b required ov_cycles=0 ir=1", seen, in_ready);
        end else n_pass++;
        start_op(16'h0001, 16'h0001, 1'b0);
        wait_done(lat);
        n_chk++;
        if (lat !== 4 || S !== 20'h00002) begin
            $display("FAIL rst_next_op: lat=%0d S=%h required lat=4 S=00002", lat, S);
        end else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_err();
        int lat;
        logic exp_err;
`ifdef BCD_INVALID_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        out_ready = 1'b0;
        start_op(16'h000A, 16'h0000, 1'b0);
        wait_done(lat);
        // 10 is above 9, so the digit stage corrects it to 0 with a carry.
        n_chk++;
        if (err !== exp_err || S !== 20'h00010 || lat !== 4) begin
            $display("FAIL err_flag: err=%b S=%h lat=%0d required err=%b S=00010 lat=4", err, S, lat, exp_err);
        end else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (err !== exp_err || out_valid !== 1'b1) begin
            $display("FAIL err_hold: err=%b ov=%b required err=%b ov=1", err, out_valid, exp_err);
        end else n_pass++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start_op(16'h0001, 16'h0002, 1'b0);
        wait_done(lat);
        n_chk++;
        if (err !== 1'b0 || S !== 20'h00003) begin
            $display("FAIL err_clear: err=%b S=%h required err=0 S=00003", err, S);
        end else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_err();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
